router_2_out_arbiter: RTL and testbench

Wormhole round-robin arbiter for one output port of router 2 in the 2x2 mesh. It owns the select input of that port's crossbar multiplexer and shares it among the N, E and L input buffers. A port keeps ownership from head flit to tail flit. Ownership passes in round-robin order only when the owner's tail flit transfers. One instance sits per output port, between the input-buffer request logic and the `xbar` select lines.

---
 rtl/router_2_out_arbiter.sv | 86 ++++++++
 tb/tb_router_2_out_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/router_2_out_arbiter.sv
// router_2_out_arbiter: wormhole round-robin arbiter owning one router-2 output port's crossbar select
//   clk, rst                 : clock, synchronous active-high reset
//   N_req/E_req/L_req        : input buffer holds a flit routed to this output
//   N_tail/E_tail/L_tail     : that buffer-head flit is a tail
//   out_ready                : downstream buffer accepts a flit this cycle
//   sel                      : crossbar select (N_PORT/E_PORT/L_PORT, NO_PORT when idle)
//   N_gnt/E_gnt/L_gnt        : pop strobe, a flit crosses this cycle
//   busy                     : a packet currently owns the port
module router_2_out_arbiter #(
    parameter logic [1:0] RR_INIT = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       N_req,
    input  logic       E_req,
    input  logic       L_req,
    input  logic       N_tail,
    input  logic       E_tail,
    input  logic       L_tail,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic       N_gnt,
    output logic       E_gnt,
    output logic       L_gnt,
    output logic       busy
);
    localparam logic [2:0] N_PORT  = 3'd0;
    localparam logic [2:0] E_PORT  = 3'd1;
    localparam logic [2:0] L_PORT  = 3'd2;
    localparam logic [2:0] NO_PORT = 3'b111;

    typedef enum logic [1:0] {IDLE, OWN_N, OWN_E, OWN_L} state_t;

    state_t     r_state, w_next;
    logic [1:0] r_ptr, w_ptr_next;
    logic [2:0] w_req, w_tail, w_own_mask, w_gnt, w_cand, w_pick;
    logic       w_own, w_tail_xfer;

    // First requester at or after start in N->E->L->N order; returns {found, port}.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
        logic [3:0] req4;
        logic [2:0] s;
        logic [1:0] idx;
        req4 = {1'b0, req};
        rr_pick = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            s = {1'b0, start} + 3'(k);
            idx = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
            if (req4[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign w_req       = {L_req, E_req, N_req};
    assign w_tail      = {L_tail, E_tail, N_tail};
    assign w_own       = r_state != IDLE;
    assign w_own_mask  = {r_state == OWN_L, r_state == OWN_E, r_state == OWN_N};
    // Gated by rst so no flit is popped while ownership is being dropped.
    assign w_gnt       = rst ? 3'b000 : (w_own_mask & w_req & {3{out_ready}});
    assign w_tail_xfer = |(w_gnt & w_tail);
    // The departing owner is excluded; in IDLE the mask is empty so all requesters compete.
    assign w_cand      = w_req & ~w_own_mask;
    assign w_pick      = rr_pick(w_cand, w_ptr_next);

    always_comb begin
        w_ptr_next = r_ptr;
        w_next = r_state;
        if (w_tail_xfer) w_ptr_next = (r_state == OWN_N) ? 2'd1 : (r_state == OWN_E) ? 2'd2 : 2'd0;
        if (!w_own || w_tail_xfer) w_next = w_pick[2] ? state_t'(w_pick[1:0] + 2'd1) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= (RR_INIT == 2'd3) ? 2'd0 : RR_INIT;
        end else begin
            r_state <= w_next;
            r_ptr <= w_ptr_next;
        end
    end

    assign sel   = (r_state == OWN_N) ? N_PORT : (r_state == OWN_E) ? E_PORT : (r_state == OWN_L) ? L_PORT : NO_PORT;
    assign busy  = w_own;
    assign N_gnt = w_gnt[0];
    assign E_gnt = w_gnt[1];
    assign L_gnt = w_gnt[2];
endmodule

// File: tb/tb_router_2_out_arbiter.sv
// tb_router_2_out_arbiter: directed and random checks of router_2_out_arbiter against an ownership/pointer model
module tb_router_2_out_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req, tl;
    logic       rdy;
    logic [2:0] sel;
    logic       n_gnt, e_gnt, l_gnt, busy;
    logic [2:0] gnt;

    int n_chk = 0;
    int n_fail = 0;
    int owner = -1;
    int ptr = 0;
    int wait_cnt [3] = '{0, 0, 0};

    router_2_out_arbiter #(.RR_INIT(2'd0)) dut (
        .clk(clk), .rst(rst),
        .N_req(req[0]), .E_req(req[1]), .L_req(req[2]),
        .N_tail(tl[0]), .E_tail(tl[1]), .L_tail(tl[2]),
        .out_ready(rdy), .sel(sel),
        .N_gnt(n_gnt), .E_gnt(e_gnt), .L_gnt(l_gnt), .busy(busy)
    );

    assign gnt = {l_gnt, e_gnt, n_gnt};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] cand, input int start);
        for (int i = 0; i < 3; i++)
            if (cand[(start + i) % 3]) return (start + i) % 3;
        return -1;
    endfunction

    // Called just after a falling edge: drive, check outputs, advance model across the rising edge.
    task automatic cyc(input logic [2:0] rq, input logic [2:0] t, input logic rd, input logic rs);
        logic [2:0] exp_gnt, c;
        logic       xfer;
        req = rq; tl = t; rdy = rd; rst = rs;
        #1;
        exp_gnt = (owner >= 0 && rq[owner] && rd && !rs) ? 3'(1 << owner) : 3'b000;
        chk("sel", 8'(sel), (owner < 0) ? 8'h07 : 8'(owner));
        chk("gnt", 8'(gnt), 8'(exp_gnt));
        chk("busy", 8'(busy), 8'(owner >= 0));
        chk("onehot", 8'($countones(gnt) <= 1), 8'd1);
        chk("gnt_sel", 8'((gnt == 3'b000) || (sel != 3'b111 && gnt == 3'(1 << sel))), 8'd1);
        for (int p = 0; p < 3; p++) begin
            if (rs || !rq[p] || gnt[p]) wait_cnt[p] = 0;
            else for (int q = 0; q < 3; q++) if (q != p && gnt[q] && t[q]) wait_cnt[p]++;
        end
        chk("starve", 8'(wait_cnt[0] <= 2 && wait_cnt[1] <= 2 && wait_cnt[2] <= 2), 8'd1);
        xfer = exp_gnt != 3'b000 && t[owner];
        @(posedge clk);
        if (rs) begin
            owner = -1;
            ptr = 0;
        end else if (owner < 0) begin
            owner = pick(rq, ptr);
        end else if (xfer) begin
            ptr = (owner + 1) % 3;
            c = rq;
            c[owner] = 1'b0;
            owner = pick(c, ptr);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; tl = '0; rdy = 1'b0;
        @(negedge clk);
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        cyc(3'b000, 3'b000, 1'b1, 1'b0);
        repeat (8) cyc(3'b111, 3'b111, 1'b1, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        cyc(3'b010, 3'b000, 1'b1, 1'b0);
        for (int f = 0; f < 4; f++)
            cyc(3'b010 | ((f >= 2) ? 3'b001 : 3'b000), (f == 3) ? 3'b010 : 3'b000, 1'b1, 1'b0);
        cyc(3'b001, 3'b001, 1'b1, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        cyc(3'b100, 3'b000, 1'b1, 1'b0);
        cyc(3'b111, 3'b011, 1'b1, 1'b0);
        cyc(3'b111, 3'b011, 1'b0, 1'b0);
        cyc(3'b111, 3'b011, 1'b0, 1'b0);
        cyc(3'b111, 3'b011, 1'b1, 1'b0);
        cyc(3'b011, 3'b011, 1'b1, 1'b0);
        cyc(3'b111, 3'b000, 1'b1, 1'b0);
        cyc(3'b111, 3'b100, 1'b1, 1'b0);
        cyc(3'b011, 3'b011, 1'b1, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        repeat (5) cyc(3'b001, 3'b001, 1'b1, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 1'b1);
        cyc(3'b001, 3'b000, 1'b1, 1'b0);
        cyc(3'b011, 3'b000, 1'b1, 1'b0);
        cyc(3'b011, 3'b000, 1'b1, 1'b1);
        cyc(3'b011, 3'b000, 1'b1, 1'b0);
        cyc(3'b011, 3'b011, 1'b1, 1'b0);
        cyc(3'b010, 3'b010, 1'b1, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            logic [2:0] rq, t;
            for (int b = 0; b < 3; b++) begin
                rq[b] = $urandom_range(0, 3) != 0;
                t[b] = $urandom_range(0, 2) == 0;
            end
            cyc(rq, t, $urandom_range(0, 3) != 0, $urandom_range(0, 1999) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
